// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key event controller:
//   - evt_type_e  : event type encodings carried on evt_type
//   - key_state_e : per-key press-classification FSM states
// ---------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        EVT_SHORT  = 2'b00,
        EVT_LONG   = 2'b01,
        EVT_REPEAT = 2'b10
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HELD = 2'b01,
        ST_LONG = 2'b10
    } key_state_e;

endpackage : key_pkg

// File: rtl/key_press_fsm.sv
// ---------------------------------------------------------------------------
// key_press_fsm
// Classifies presses of one debounced key into SHORT / LONG (and, when the
// KEY_EVT_AUTO_REPEAT_EN macro is defined, periodic REPEAT) events.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   asynchronous active-low reset
//   key_level  in   debounced key level (polarity set by ACTIVE_LOW)
//   evt_raise  out  one-cycle strobe: an event is raised this cycle
//   evt_type   out  type of the raised event (valid with evt_raise)
//
// Build option: `define KEY_EVT_AUTO_REPEAT_EN adds the repeat counter.
// ---------------------------------------------------------------------------
module key_press_fsm
    import key_pkg::*;
#(
    parameter int CNT_W      = 26,
    parameter int LONG_CNT   = 32'sd50_000_000,
`ifdef KEY_EVT_AUTO_REPEAT_EN
    parameter int REPEAT_CNT = 32'sd10_000_000,
`endif
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic      sys_clk,
    input  logic      sys_rst,
    input  logic      key_level,
    output logic      evt_raise,
    output evt_type_e evt_type
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
`ifdef KEY_EVT_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 32'sd1);
`endif

    logic             pressed_s;
    logic             press_edge_s;
    logic             prev_r;
    key_state_e       state_r;
    key_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             raise_s;
    evt_type_e        raise_type_s;
`ifdef KEY_EVT_AUTO_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt_r;
    logic [CNT_W-1:0] rep_nxt_s;
`endif

    assign pressed_s    = key_level ^ ACTIVE_LOW;
    // prev_r resets to "released", so a key held through reset gives an edge.
    assign press_edge_s = pressed_s & ~prev_r;

    // State, hold counter and previous-level register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            prev_r    <= 1'b0;
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
`ifdef KEY_EVT_AUTO_REPEAT_EN
            rep_cnt_r <= CNT_ZERO;
`endif
        end else begin
            prev_r    <= pressed_s;
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
`ifdef KEY_EVT_AUTO_REPEAT_EN
            rep_cnt_r <= rep_nxt_s;
`endif
        end
    end

    // Next-state, counter update and event raise strobe.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        raise_s      = 1'b0;
        raise_type_s = EVT_SHORT;
`ifdef KEY_EVT_AUTO_REPEAT_EN
        rep_nxt_s    = rep_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (press_edge_s) begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HELD: begin
                // A release is checked first: releasing on the threshold cycle is still SHORT.
                if (!pressed_s) begin
                    raise_s      = 1'b1;
                    raise_type_s = EVT_SHORT;
                    state_nxt_s  = ST_IDLE;
                end else if (cnt_r == LONG_LAST) begin
                    raise_s      = 1'b1;
                    raise_type_s = EVT_LONG;
                    state_nxt_s  = ST_LONG;
`ifdef KEY_EVT_AUTO_REPEAT_EN
                    rep_nxt_s    = CNT_ZERO;
`endif
                end else if (cnt_r != CNT_MAX) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_LONG: begin
                if (!pressed_s) begin
                    state_nxt_s = ST_IDLE;
`ifdef KEY_EVT_AUTO_REPEAT_EN
                    rep_nxt_s   = CNT_ZERO;
`endif
                end else begin
                    state_nxt_s = ST_LONG;
`ifdef KEY_EVT_AUTO_REPEAT_EN
                    if (rep_cnt_r == REP_LAST) begin
                        raise_s      = 1'b1;
                        raise_type_s = EVT_REPEAT;
                        rep_nxt_s    = CNT_ZERO;
                    end else begin
                        rep_nxt_s    = rep_cnt_r + CNT_ONE;
                    end
`endif
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    assign evt_raise = raise_s;
    assign evt_type  = raise_type_s;

endmodule : key_press_fsm

// File: rtl/key_event_ctrl.sv
// ---------------------------------------------------------------------------
// key_event_ctrl
// Per-key press classification, one pending slot per key, and a round-robin
// arbiter feeding a registered valid/ready event port.
//
// Ports:
//   sys_clk     in   system clock
//   sys_rst     in   asynchronous active-low reset
//   key_status  in   NUM_KEYS debounced key levels (sys_clk synchronous)
//   evt_valid   out  event available
//   evt_ready   in   consumer accepts the event
//   evt_key     out  index of the key that produced the event
//   evt_type    out  00 SHORT, 01 LONG, 10 REPEAT
//   evt_drop    out  one-cycle pulse: a pending event was overwritten
//
// Build option: `define KEY_EVT_AUTO_REPEAT_EN enables REPEAT events.
// ---------------------------------------------------------------------------
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int NUM_KEYS   = 4,
    parameter int KEY_W      = 2,
    parameter int CNT_W      = 26,
    parameter int LONG_CNT   = 32'sd50_000_000,
    parameter int REPEAT_CNT = 32'sd10_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_status,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_key,
    output logic [1:0]          evt_type,
    output logic                evt_drop
);

    if ((NUM_KEYS < 32'sd2) || (NUM_KEYS > 32'sd8) || (KEY_W != $clog2(NUM_KEYS)) ||
        (LONG_CNT < 32'sd1) || (REPEAT_CNT < 32'sd1) ||
        (longint'(LONG_CNT) > (64'sd1 << CNT_W)) ||
        (longint'(REPEAT_CNT) > (64'sd1 << CNT_W))) begin : g_cfg_check
        $error("key_event_ctrl: illegal parameter combination");
    end

    logic [NUM_KEYS-1:0] raise_s;
    evt_type_e           raise_type_s [NUM_KEYS];
    logic [NUM_KEYS-1:0] pend_valid_r;
    evt_type_e           pend_type_r  [NUM_KEYS];
    logic [NUM_KEYS-1:0] gnt_s;
    logic [NUM_KEYS-1:0] drop_s;
    logic                load_s;
    logic                found_s;
    int                  cand_s;
    logic [KEY_W-1:0]    cand_idx_s;
    logic [KEY_W-1:0]    gnt_idx_s;
    logic [KEY_W-1:0]    rr_ptr_r;
    logic [KEY_W-1:0]    rr_nxt_s;
    logic                evt_valid_r;
    logic [KEY_W-1:0]    evt_key_r;
    evt_type_e           evt_type_r;
    logic                evt_drop_r;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_press_fsm #(
            .CNT_W      (CNT_W),
            .LONG_CNT   (LONG_CNT),
`ifdef KEY_EVT_AUTO_REPEAT_EN
            .REPEAT_CNT (REPEAT_CNT),
`endif
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_fsm (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .key_level (key_status[k]),
            .evt_raise (raise_s[k]),
            .evt_type  (raise_type_s[k])
        );
    end

    // Round-robin search from rr_ptr_r; grant only when the output register can load.
    always_comb begin
        load_s     = ~evt_valid_r | evt_ready;
        found_s    = 1'b0;
        gnt_idx_s  = {KEY_W{1'b0}};
        cand_s     = 32'sd0;
        cand_idx_s = {KEY_W{1'b0}};
        for (int i = 0; i < NUM_KEYS; i++) begin
            cand_s     = int'(rr_ptr_r) + i;
            cand_s     = (cand_s >= NUM_KEYS) ? (cand_s - NUM_KEYS) : cand_s;
            cand_idx_s = KEY_W'(cand_s);
            if (pend_valid_r[cand_idx_s] && !found_s) begin
                found_s   = 1'b1;
                gnt_idx_s = cand_idx_s;
            end else begin
                found_s   = found_s;
                gnt_idx_s = gnt_idx_s;
            end
        end
        gnt_s            = {NUM_KEYS{1'b0}};
        gnt_s[gnt_idx_s] = load_s & found_s;
        rr_nxt_s = (int'(gnt_idx_s) == (NUM_KEYS - 32'sd1)) ? {KEY_W{1'b0}}
                                                            : gnt_idx_s + KEY_W'(32'd1);
    end

    // A raise overwrites a slot that is still valid unless that slot leaves this cycle.
    assign drop_s = raise_s & pend_valid_r & ~gnt_s;

    // Pending slots and the registered drop pulse.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pend_valid_r <= {NUM_KEYS{1'b0}};
            evt_drop_r   <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                pend_type_r[k] <= EVT_SHORT;
            end
        end else begin
            evt_drop_r <= |drop_s;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (raise_s[k]) begin
                    pend_valid_r[k] <= 1'b1;
                    pend_type_r[k]  <= raise_type_s[k];
                end else if (gnt_s[k]) begin
                    pend_valid_r[k] <= 1'b0;
                end
            end
        end
    end

    // Output register; key/type only change when a new event is loaded.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            evt_valid_r <= 1'b0;
            evt_key_r   <= {KEY_W{1'b0}};
            evt_type_r  <= EVT_SHORT;
            rr_ptr_r    <= {KEY_W{1'b0}};
        end else if (load_s) begin
            evt_valid_r <= found_s;
            if (found_s) begin
                evt_key_r  <= gnt_idx_s;
                evt_type_r <= pend_type_r[gnt_idx_s];
                rr_ptr_r   <= rr_nxt_s;
            end
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_key   = evt_key_r;
    assign evt_type  = evt_type_r;
    assign evt_drop  = evt_drop_r;

endmodule : key_event_ctrl
